la_capture_ctrl: RTL and testbench

LA_CAPTURE_CTRL -- requirements
Module: la_capture_ctrl

---
 rtl/la_capture_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_la_capture_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl: logic-analyser capture controller.
// Arms on a command, records pre-trigger history into a circular sample
// buffer, waits for a masked pattern match, fills the remaining buffer with
// post-trigger samples, then streams the whole buffer (oldest first) to a
// ready/valid consumer.
// Ports:
//   i_clk, i_rst                    clock, async active-high reset
//   i_sample_stb, i_sample_data     incoming samples
//   i_capture_cmd, i_abort          arm pulse, abort request
//   i_pretrig, i_trig_mask/value    capture setup, latched on arm
//   o_write_*                       buffer write port
//   o_read_*, i_read_data           buffer read port (1-cycle read latency)
//   o_tx_data, o_tx_en, i_tx_ready  readout stream
//   o_busy, o_done, o_trig_address  status
module la_capture_ctrl #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sample_stb,
    input  logic [DATA_W-1:0] i_sample_data,
    input  logic              i_capture_cmd,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_pretrig,
    input  logic [DATA_W-1:0] i_trig_mask,
    input  logic [DATA_W-1:0] i_trig_value,
    output logic [DATA_W-1:0] o_write_data,
    output logic [ADDR_W-1:0] o_write_address,
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_read_address,
    output logic              o_read_en,
    input  logic [DATA_W-1:0] i_read_data,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_en,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_trig_address
);

    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};  // DEPTH-1

    typedef enum logic [2:0] {
        S_IDLE, S_PRETRIG, S_ARMED, S_POST, S_TRANSFER, S_DONE
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, cnt, cnt_n;
    logic [ADDR_W-1:0] pretrig_q, pretrig_n, trig_addr_n;
    logic [DATA_W-1:0] mask_q, mask_n, value_q, value_n;
    logic [DATA_W-1:0] wr_data_n, tx_data_n;
    logic [ADDR_W-1:0] wr_addr_n, rd_addr_n;
    logic              wr_en_n, rd_en_n, rd_wait, rd_wait_n, tx_en_n;
    logic              busy_n, done_n;
    logic [ADDR_W-1:0] post_last;
    logic              match;

    // Post-trigger sample count is DEPTH-1-pretrig, i.e. ~pretrig.
    assign post_last = ADDR_W'(~pretrig_q - ONE);
    assign match     = ((i_sample_data & mask_q) == (value_q & mask_q));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr;
        rd_ptr_n    = rd_ptr;
        cnt_n       = cnt;
        pretrig_n   = pretrig_q;
        mask_n      = mask_q;
        value_n     = value_q;
        trig_addr_n = o_trig_address;
        wr_en_n     = 1'b0;
        wr_data_n   = o_write_data;
        wr_addr_n   = o_write_address;
        rd_en_n     = 1'b0;
        rd_addr_n   = o_read_address;
        rd_wait_n   = 1'b0;
        tx_en_n     = o_tx_en;
        tx_data_n   = o_tx_data;

        case (state)
            S_IDLE: begin
                tx_en_n = 1'b0;
                if (i_capture_cmd) begin
                    pretrig_n = i_pretrig;
                    mask_n    = i_trig_mask;
                    value_n   = i_trig_value;
                    wr_ptr_n  = '0;
                    cnt_n     = '0;
                    state_n   = (i_pretrig == '0) ? S_ARMED : S_PRETRIG;
                end
            end
            S_PRETRIG, S_ARMED, S_POST: begin
                if (i_sample_stb) begin
                    wr_en_n   = 1'b1;
                    wr_data_n = i_sample_data;
                    wr_addr_n = wr_ptr;
                    wr_ptr_n  = wr_ptr + ONE;
                    cnt_n     = cnt + ONE;
                    case (state)
                        S_PRETRIG: begin
                            if (cnt == ADDR_W'(pretrig_q - ONE)) begin
                                cnt_n   = '0;
                                state_n = S_ARMED;
                            end
                        end
                        S_ARMED: begin
                            cnt_n = '0;
                            if (match) begin
                                trig_addr_n = wr_ptr;
                                rd_ptr_n    = ADDR_W'(wr_ptr - pretrig_q);
                                state_n     = (pretrig_q == LAST) ? S_TRANSFER : S_POST;
                            end
                        end
                        default: begin
                            if (cnt == post_last) begin
                                cnt_n   = '0;
                                state_n = S_TRANSFER;
                            end
                        end
                    endcase
                end
            end
            S_TRANSFER: begin
                // Per word: read pulse, wait one cycle for data, present until accepted.
                rd_wait_n = o_read_en;
                if (rd_wait) begin
                    tx_data_n = i_read_data;
                    tx_en_n   = 1'b1;
                end else if (o_tx_en) begin
                    if (i_tx_ready) begin
                        tx_en_n  = 1'b0;
                        rd_ptr_n = rd_ptr + ONE;
                        cnt_n    = cnt + ONE;
                        if (cnt == LAST) state_n = S_DONE;
                    end
                end else if (!o_read_en) begin
                    rd_en_n   = 1'b1;
                    rd_addr_n = rd_ptr;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Abort overrides everything outside IDLE.
        if (i_abort && (state != S_IDLE)) begin
            state_n   = S_IDLE;
            wr_en_n   = 1'b0;
            rd_en_n   = 1'b0;
            rd_wait_n = 1'b0;
            tx_en_n   = 1'b0;
        end

        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cnt             <= '0;
            pretrig_q       <= '0;
            mask_q          <= '0;
            value_q         <= '0;
            rd_wait         <= 1'b0;
            o_trig_address  <= '0;
            o_write_en      <= 1'b0;
            o_write_data    <= '0;
            o_write_address <= '0;
            o_read_en       <= 1'b0;
            o_read_address  <= '0;
            o_tx_en         <= 1'b0;
            o_tx_data       <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr_n;
            rd_ptr          <= rd_ptr_n;
            cnt             <= cnt_n;
            pretrig_q       <= pretrig_n;
            mask_q          <= mask_n;
            value_q         <= value_n;
            rd_wait         <= rd_wait_n;
            o_trig_address  <= trig_addr_n;
            o_write_en      <= wr_en_n;
            o_write_data    <= wr_data_n;
            o_write_address <= wr_addr_n;
            o_read_en       <= rd_en_n;
            o_read_address  <= rd_addr_n;
            o_tx_en         <= tx_en_n;
            o_tx_data       <= tx_data_n;
            o_busy          <= busy_n;
            o_done          <= done_n;
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Testbench for la_capture_ctrl with a 16-deep buffer model.
module tb_la_capture_ctrl;

    localparam int unsigned DW    = 12;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_stb = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          capture_cmd = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] pretrig = '0;
    logic [DW-1:0] trig_mask = '0;
    logic [DW-1:0] trig_value = '0;
    logic [DW-1:0] write_data;
    logic [AW-1:0] write_address;
    logic          write_en;
    logic [AW-1:0] read_address;
    logic          read_en;
    logic [DW-1:0] read_data = '0;
    logic [DW-1:0] tx_data;
    logic          tx_en;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] trig_address;

    always #5 clk = ~clk;

    la_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_sample_stb(sample_stb), .i_sample_data(sample_data),
        .i_capture_cmd(capture_cmd), .i_abort(abort),
        .i_pretrig(pretrig), .i_trig_mask(trig_mask), .i_trig_value(trig_value),
        .o_write_data(write_data), .o_write_address(write_address), .o_write_en(write_en),
        .o_read_address(read_address), .o_read_en(read_en), .i_read_data(read_data),
        .o_tx_data(tx_data), .o_tx_en(tx_en), .i_tx_ready(tx_ready),
        .o_busy(busy), .o_done(done), .o_trig_address(trig_address)
    );

    // Sample buffer: synchronous write, 1-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (write_en) mem[write_address] <= write_data;
        if (read_en)  read_data <= mem[read_address];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wr_q[$];
    logic [DW-1:0] tx_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops scoreboard entries as the DUT presents writes and accepted words.
    wr_t           w;
    logic [DW-1:0] exp_tx;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (write_en) begin
            if (wr_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_write: addr %0h data %0h at %0t", write_address, write_data, $time);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", 32'(write_address), 32'(w.a));
                check("wr_data", 32'(write_data), 32'(w.d));
            end
        end
        if (hold_prev && !rst) begin
            check("stall_tx_en", 32'(tx_en), 32'd1);
            check("stall_tx_data", 32'(tx_data), 32'(hold_data));
        end
        if (tx_en && tx_ready) begin
            if (tx_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_tx: data %0h at %0t", tx_data, $time);
            end else begin
                exp_tx = tx_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(exp_tx));
            end
        end
        hold_prev = tx_en && !tx_ready && !rst;
        hold_data = tx_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [AW-1:0] pt, input logic [DW-1:0] m, input logic [DW-1:0] v);
        tick();
        capture_cmd = 1'b1; pretrig = pt; trig_mask = m; trig_value = v;
        tick();
        capture_cmd = 1'b0;
    endtask

    task automatic strobe(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            sample_stb = 1'b1;
            sample_data = DW'(base + i);
            tick();
        end
        sample_stb = 1'b0;
    endtask

    // nwr writes of base+i at i mod DEPTH; readout is DEPTH words from base+tx_start.
    task automatic push_exp(input int base, input int nwr, input int tx_start, input bit with_tx);
        wr_t e;
        for (int i = 0; i < nwr; i++) begin
            e.a = AW'(i % DEPTH);
            e.d = DW'(base + i);
            wr_q.push_back(e);
        end
        if (with_tx)
            for (int k = 0; k < DEPTH; k++) tx_q.push_back(DW'(base + tx_start + k));
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        for (k = 0; k < max; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (k == max) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: busy still %0d after %0d cycles", name, busy, max);
        end
    endtask

    task automatic wait_tx(input string name, input int max);
        int k;
        for (k = 0; k < max; k++) begin
            @(negedge clk);
            if (tx_en) break;
        end
        if (k == max) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: tx_en still %0d after %0d cycles", name, tx_en, max);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_write_en"}, 32'(write_en), 0);
        check({tag, "_read_en"}, 32'(read_en), 0);
        check({tag, "_tx_en"}, 32'(tx_en), 0);
        check({tag, "_trig_address"}, 32'(trig_address), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Ramp capture, pretrig 4, exact match on 0x00A; cmd pulse in ARMED, extra strobes in TRANSFER.
        push_exp(0, 22, 6, 1'b1);
        tx_ready = 1'b1;
        arm(4'd4, 12'hFFF, 12'h00A);
        for (int i = 0; i < 26; i++) begin
            sample_stb  = 1'b1;
            sample_data = DW'(i);
            capture_cmd = (i == 7);
            if (i == 7) begin pretrig = 4'd3; trig_mask = '0; end
            tick();
        end
        sample_stb = 1'b0; capture_cmd = 1'b0;
        wait_idle("ramp", 500);
        check("ramp_trig_address", 32'(trig_address), 32'd10);
        check("ramp_done_count", 32'(done_cnt), 32'd1);
        check("ramp_wr_left", 32'(wr_q.size()), 0);
        check("ramp_tx_left", 32'(tx_q.size()), 0);

        // Pretrig 0, mask 0: trigger on first sample; consumer stalls 20 cycles with a cmd pulse.
        push_exp('h100, 16, 0, 1'b1);
        tx_ready = 1'b0;
        arm(4'd0, 12'h000, 12'h123);
        strobe('h100, 16);
        wait_tx("stall", 100);
        for (int c = 0; c < 20; c++) begin
            capture_cmd = (c == 5);
            tick();
        end
        capture_cmd = 1'b0;
        tx_ready = 1'b1;
        wait_idle("stall", 500);
        check("stall_trig_address", 32'(trig_address), 32'd0);
        check("stall_done_count", 32'(done_cnt), 32'd2);
        check("stall_wr_left", 32'(wr_q.size()), 0);
        check("stall_tx_left", 32'(tx_q.size()), 0);

        // Abort in POST, then rearm from address 0.
        push_exp('h200, 9, 0, 1'b0);
        arm(4'd2, 12'hFFF, 12'h205);
        strobe('h200, 9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_write_en", 32'(write_en), 0);
        repeat (3) tick();
        check("abort_done_count", 32'(done_cnt), 32'd2);
        check("abort_wr_left", 32'(wr_q.size()), 0);
        push_exp('h300, 16, 0, 1'b1);
        arm(4'd0, 12'h000, 12'h000);
        strobe('h300, 16);
        wait_idle("rearm", 500);
        check("rearm_done_count", 32'(done_cnt), 32'd3);
        check("rearm_tx_left", 32'(tx_q.size()), 0);

        // Reset in the middle of TRANSFER clears every output at once.
        push_exp('h500, 16, 0, 1'b0);
        tx_ready = 1'b0;
        arm(4'd0, 12'h000, 12'h000);
        strobe('h500, 16);
        wait_tx("midrst", 100);
        tick();
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        check("midrst_tx_data", 32'(tx_data), 0);
        check("midrst_read_address", 32'(read_address), 0);
        check("midrst_write_address", 32'(write_address), 0);
        check("midrst_wr_left", 32'(wr_q.size()), 0);
        repeat (2) tick();
        rst = 1'b0;

        // Pretrig 15, trigger on 16th sample: no POST, readout from address 0.
        push_exp('h400, 16, 0, 1'b1);
        tx_ready = 1'b1;
        arm(4'd15, 12'hFFF, 12'h40F);
        strobe('h400, 16);
        wait_idle("full_pre", 500);
        check("full_pre_trig_address", 32'(trig_address), 32'd15);
        check("full_pre_done_count", 32'(done_cnt), 32'd4);
        check("full_pre_wr_left", 32'(wr_q.size()), 0);
        check("full_pre_tx_left", 32'(tx_q.size()), 0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
